imu_axis_averager: RTL

Six-axis moving-average filter downstream of the I2C sensor driver. It takes each complete raw sample set (accelerometer X/Y/Z, magnetometer X/Y/Z) and keeps a per-axis ring buffer of the last 2^LOG2_DEPTH samples. It emits the rounded-down mean of each axis to the object-tracking datapath. Axes are processed one per cycle through a single shared adder.

---
 rtl/imu_axis_averager.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imu_axis_averager.sv
// Six-axis moving-average filter; one axis per cycle through a shared adder.
// Optional IMU_AVG_PRIME_GATE_EN: hold off out_valid until the window is primed.
module imu_axis_averager #(
    parameter int LOG2_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] acl_x,
    input  logic [15:0] acl_y,
    input  logic [15:0] acl_z,
    input  logic [15:0] mag_x,
    input  logic [15:0] mag_y,
    input  logic [15:0] mag_z,
    output logic [15:0] avg_acl_x,
    output logic [15:0] avg_acl_y,
    output logic [15:0] avg_acl_z,
    output logic [15:0] avg_mag_x,
    output logic [15:0] avg_mag_y,
    output logic [15:0] avg_mag_z,
    output logic        out_valid,
    output logic        primed,
    output logic        overrun
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = 16 + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
    state_e state_q, state_d;

    logic [15:0]           raw    [6];
    logic [15:0]           cap_q  [6];
    logic [15:0]           hist_q [6][DEPTH];
    logic signed [SW-1:0]  sum_q  [6];
    logic [15:0]           avg_q  [6];
    logic [2:0]            idx_q;
    logic [LOG2_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_DEPTH:0]   cnt_q, cnt_d;
    logic                  primed_q, overrun_q;
    logic                  last_axis;
    logic signed [SW-1:0]  new_s, old_s, sum_d;

    assign raw[0] = acl_x;
    assign raw[1] = acl_y;
    assign raw[2] = acl_z;
    assign raw[3] = mag_x;
    assign raw[4] = mag_y;
    assign raw[5] = mag_z;

    assign last_axis = (idx_q == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = ACCUM;
            ACCUM:   if (last_axis) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
`ifdef IMU_AVG_PRIME_GATE_EN
        out_valid = (state_q == DONE) && primed_q;
`else
        out_valid = (state_q == DONE);
`endif
    end

    // Shared adder: add the incoming sample, retire the oldest one
    always_comb begin
        new_s = {{LOG2_DEPTH{cap_q[idx_q][15]}}, cap_q[idx_q]};
        old_s = {{LOG2_DEPTH{hist_q[idx_q][wr_ptr_q][15]}},
                 hist_q[idx_q][wr_ptr_q]};
        sum_d = sum_q[idx_q] + new_s - old_s;
        cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                cap_q[i] <= '0;
                sum_q[i] <= '0;
                avg_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) hist_q[i][j] <= '0;
            end
            idx_q     <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            primed_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (in_valid && state_q != IDLE) overrun_q <= 1'b1;
            unique case (state_q)
                IDLE: if (in_valid) begin
                    cap_q <= raw;
                    idx_q <= '0;
                end
                ACCUM: begin
                    sum_q[idx_q]            <= sum_d;
                    hist_q[idx_q][wr_ptr_q] <= cap_q[idx_q];
                    avg_q[idx_q]            <= sum_d[LOG2_DEPTH +: 16];
                    idx_q                   <= idx_q + 3'd1;
                    // Count here so primed lines up with the DONE pulse
                    if (last_axis) begin
                        cnt_q    <= cnt_d;
                        primed_q <= (cnt_d == FULL);
                    end
                end
                DONE:    wr_ptr_q <= wr_ptr_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign avg_acl_x = avg_q[0];
    assign avg_acl_y = avg_q[1];
    assign avg_acl_z = avg_q[2];
    assign avg_mag_x = avg_q[3];
    assign avg_mag_y = avg_q[4];
    assign avg_mag_z = avg_q[5];
    assign primed    = primed_q;
    assign overrun   = overrun_q;

endmodule
